tdm_demux_16: RTL and testbench

Receive-side counterpart of the 16-channel time-division mux path. Takes a single serial bit stream that carries one bit per channel slot, and tracks the slot index with an internal counter. Once all 16 slots of a frame have arrived, it presents the bits as a 16-bit parallel word through a valid/ready handshake. It sits between the serial link and the per-channel consumer logic.

---
 rtl/tdm_demux_16_pkg.sv | 21 ++
 rtl/tdm_demux_16_demux_1_to_4.sv | 16 +
 rtl/tdm_demux_16.sv | 163 ++++++++++++++++
 tb/tb_tdm_demux_16.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_16_pkg.sv
// tdm_pkg: shared defaults and types for the 16-channel TDM receive path.
// Optional build macro: TDM_PARITY_EN. When it is defined, each frame carries
// one extra even-parity slot.
package tdm_pkg;

  // Default channel count and slot index width (log2 of the channel count)
  localparam int N_CH_DEF  = 16;
  localparam int SEL_W_DEF = 4;

  // Receive FSM. COMPLETE lasts one cycle after the last slot of a frame. It
  // accepts a new frame_start exactly like IDLE, so frames can run back to back.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    COMPLETE = 2'd2
  } state_e;

  // One assembled frame; bit k holds slot k
  typedef logic [N_CH_DEF-1:0] frame_t;

endpackage

// File: rtl/tdm_demux_16_demux_1_to_4.sv
// demux_1_to_4: 1-to-4 one-hot decoder with enable. It is the building block
// of the slot write-enable tree. This module has no build options; the
// optional TDM_PARITY_EN feature of the demux lives in the top level.
module demux_1_to_4 (
  input  logic       en,
  input  logic [1:0] sel,
  output logic [3:0] y
);

  // One-hot select, all zero when disabled
  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux_16.sv
// tdm_demux_16: serial-to-parallel TDM receiver. One bit arrives per channel
// slot. A complete frame is presented as a parallel word through a
// valid/ready handshake.
// Optional build macro: TDM_PARITY_EN. It adds an even-parity slot at index
// N_CH and a sticky parity_err output; frames with bad parity are dropped.
module tdm_demux_16
  import tdm_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_bit,
  input  logic            in_valid,
  input  logic            frame_start,
  output logic [N_CH-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
`ifdef TDM_PARITY_EN
  output logic [SEL_W:0]  slot_idx,
  output logic            parity_err,
`else
  output logic [SEL_W-1:0] slot_idx,
`endif
  output logic            overrun,
  output logic            sync_err,
  input  logic            err_clr
);

`ifdef TDM_PARITY_EN
  // The slot counter is one bit wider so that it can reach the parity slot
  localparam int CNT_W = SEL_W + 1;
  localparam int LAST  = N_CH;
`else
  localparam int CNT_W = SEL_W;
  localparam int LAST  = N_CH - 1;
`endif
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(LAST);
  localparam logic [CNT_W-1:0] SLOT_ONE  = CNT_W'(1);

  state_e          state;
  logic [N_CH-1:0] shadow;

  logic            start, collecting, restart, begin_frame, step, last;
  logic            wr_first, data_slot, dec_en;
  logic [SEL_W-1:0] dec_idx;
  logic [3:0]      idx4;
  logic [3:0]      grp_en;
  logic [3:0][3:0] we_grp;
  logic [15:0]     we16;
  logic [N_CH-1:0] we, shadow_base, shadow_wr, frame_word;
  logic            parity_ok, frame_good, deliver, lost;

  // Classify the current input cycle against the FSM state
  always_comb begin
    start       = in_valid & frame_start;
    collecting  = (state == COLLECT);
    restart     = collecting & start;             // frame_start arrived mid-frame
    begin_frame = ~collecting & start;            // IDLE or COMPLETE
    step        = collecting & in_valid & ~frame_start;
    last        = step & (slot_idx == LAST_SLOT);
    wr_first    = begin_frame | restart;
`ifdef TDM_PARITY_EN
    data_slot   = step & (slot_idx != LAST_SLOT); // the parity slot never writes the shadow
`else
    data_slot   = step;
`endif
    dec_en      = wr_first | data_slot;
    dec_idx     = wr_first ? '0 : slot_idx[SEL_W-1:0];
    idx4        = 4'(dec_idx);
  end

  // 4-to-16 write-enable tree: the root decodes the upper index pair and
  // enables one of four leaves, each of which decodes the lower pair
  demux_1_to_4 u_root (
    .en  (dec_en),
    .sel (idx4[3:2]),
    .y   (grp_en)
  );

  for (genvar g = 0; g < 4; g++) begin : g_leaf
    demux_1_to_4 u_leaf (
      .en  (grp_en[g]),
      .sel (idx4[1:0]),
      .y   (we_grp[g])
    );
  end

  assign we16 = we_grp;
  assign we   = we16[N_CH-1:0];

  // Merge the incoming bit into the shadow. A restart discards the partial frame first.
  always_comb begin
    shadow_base = restart ? '0 : shadow;
    shadow_wr   = (shadow_base & ~we) | (we & {N_CH{in_bit}});
`ifdef TDM_PARITY_EN
    frame_word  = shadow;
    parity_ok   = ((^shadow) == in_bit);
`else
    frame_word  = shadow_wr;
    parity_ok   = 1'b1;
`endif
    frame_good  = last & parity_ok;
    deliver     = frame_good & (~out_valid | out_ready);
    lost        = frame_good & out_valid & ~out_ready;
  end

  // FSM, slot counter and shadow register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      slot_idx <= '0;
      shadow   <= '0;
    end else if (wr_first) begin
      state    <= COLLECT;
      slot_idx <= SLOT_ONE;
      shadow   <= shadow_wr;
    end else if (last) begin
      state    <= COMPLETE;
      slot_idx <= '0;
      shadow   <= '0;
    end else if (step) begin
      slot_idx <= slot_idx + SLOT_ONE;
      shadow   <= shadow_wr;
    end else if (state == COMPLETE) begin
      state    <= IDLE;
    end
  end

  // Output register. A completed frame may replace a frame that is being taken this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (deliver) begin
      out_data  <= frame_word;
      out_valid <= 1'b1;
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky error flags. A new error in the same cycle overrides err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun  <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      overrun  <= lost    | (overrun  & ~err_clr);
      sync_err <= restart | (sync_err & ~err_clr);
    end
  end

`ifdef TDM_PARITY_EN
  // Sticky parity error: a frame was dropped for bad parity
  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= (last & ~parity_ok) | (parity_err & ~err_clr);
  end
`endif

endmodule

// File: tb/tb_tdm_demux_16.sv
// tb_tdm_demux_16: directed self-checking bench for tdm_demux_16 in the
// default build, with TDM_PARITY_EN undefined.
module tb_tdm_demux_16;

  logic        clk = 1'b0;
  logic        rst, in_bit, in_valid, frame_start, out_ready, err_clr;
  logic [15:0] out_data;
  logic        out_valid, overrun, sync_err;
  logic [3:0]  slot_idx;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int c0;

  logic        mon_en = 1'b0;
  logic [15:0] mon_q[$];

  tdm_demux_16 dut (
    .clk         (clk),
    .rst         (rst),
    .in_bit      (in_bit),
    .in_valid    (in_valid),
    .frame_start (frame_start),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .slot_idx    (slot_idx),
    .overrun     (overrun),
    .sync_err    (sync_err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every accepted output word while monitoring is enabled
  always @(negedge clk) if (mon_en && out_valid && out_ready) mon_q.push_back(out_data);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_bit(input logic b, input logic fs);
    in_valid = 1'b1; in_bit = b; frame_start = fs;
    @(posedge clk); #1;
    in_valid = 1'b0; in_bit = 1'b0; frame_start = 1'b0;
  endtask

  // Send one 16-slot frame. The arguments are an optional idle gap before
  // slot gap_at, and optional ready or err_clr pulses on the last bit.
  task automatic send_frame(input logic [15:0] w, input int gap_at, input int gap_len,
                            input logic rdy_last, input logic clr_last);
    logic save_rdy;
    save_rdy = out_ready;
    for (int k = 0; k < 16; k++) begin
      if (k == gap_at) begin
        idle(gap_len);
        chk("gap_slot_idx", 32'(slot_idx), 32'(gap_at));
        chk("gap_no_valid", 32'(out_valid), 32'd0);
      end
      if (k == 15) begin
        if (rdy_last) out_ready = 1'b1;
        if (clr_last) err_clr = 1'b1;
      end
      send_bit(w[k], k == 0);
    end
    out_ready = save_rdy;
    err_clr   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_bit = 1'b0; in_valid = 1'b0; frame_start = 1'b0;
    out_ready = 1'b0; err_clr = 1'b0;
    idle(2);
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_slot_idx",  32'(slot_idx),  32'd0);
    chk("rst_overrun",   32'(overrun),   32'd0);
    chk("rst_sync_err",  32'(sync_err),  32'd0);

    // Basic frame: valid one cycle after the last bit
    idle(1);
    c0 = cyc;
    send_frame(16'hA5C3, 99, 0, 1'b0, 1'b0);
    chk("f1_latency",   32'(cyc - c0),  32'd16);
    chk("f1_out_valid", 32'(out_valid), 32'd1);
    chk("f1_out_data",  32'(out_data),  32'hA5C3);
    chk("f1_slot_idx",  32'(slot_idx),  32'd0);
    out_ready = 1'b1; idle(1); out_ready = 1'b0;
    chk("f1_consumed",  32'(out_valid), 32'd0);

    // Same frame with a 3-cycle hole at slot 7
    c0 = cyc;
    send_frame(16'hA5C3, 7, 3, 1'b0, 1'b0);
    chk("f2_latency",   32'(cyc - c0),  32'd19);
    chk("f2_out_valid", 32'(out_valid), 32'd1);
    chk("f2_out_data",  32'(out_data),  32'hA5C3);
    out_ready = 1'b1; idle(1); out_ready = 1'b0;
    chk("f2_consumed",  32'(out_valid), 32'd0);

    // Overrun: the second frame is dropped and the first is retained
    send_frame(16'h1234, 99, 0, 1'b0, 1'b0);
    chk("ov_first_data", 32'(out_data), 32'h1234);
    send_frame(16'hFFFF, 99, 0, 1'b0, 1'b0);
    chk("ov_flag",       32'(overrun),   32'd1);
    chk("ov_keep_data",  32'(out_data),  32'h1234);
    chk("ov_keep_valid", 32'(out_valid), 32'd1);
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    chk("ov_cleared",    32'(overrun),   32'd0);
    // A new overrun in the same cycle as err_clr keeps the flag set
    send_frame(16'h0F0F, 99, 0, 1'b0, 1'b1);
    chk("ov_beats_clr",  32'(overrun),   32'd1);
    chk("ov_keep_data2", 32'(out_data),  32'h1234);
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    chk("ov_cleared2",   32'(overrun),   32'd0);
    // A ready pulse on the completing cycle lets the new frame replace the old
    send_frame(16'h5555, 99, 0, 1'b1, 1'b0);
    chk("rep_data",      32'(out_data),  32'h5555);
    chk("rep_valid",     32'(out_valid), 32'd1);
    chk("rep_no_ov",     32'(overrun),   32'd0);
    out_ready = 1'b1; idle(1); out_ready = 1'b0;
    chk("rep_consumed",  32'(out_valid), 32'd0);

    // Sync error: frame_start at slot 9 discards a partial frame of all ones
    for (int k = 0; k < 9; k++) send_bit(1'b1, k == 0);
    chk("se_slot_idx",  32'(slot_idx),  32'd9);
    chk("se_pre_flag",  32'(sync_err),  32'd0);
    send_frame(16'h00FF, 99, 0, 1'b0, 1'b0);
    chk("se_flag",      32'(sync_err),  32'd1);
    chk("se_out_data",  32'(out_data),  32'h00FF);
    chk("se_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1; err_clr = 1'b1; idle(1); out_ready = 1'b0; err_clr = 1'b0;
    chk("se_cleared",   32'(sync_err),  32'd0);
    chk("se_consumed",  32'(out_valid), 32'd0);

    // Back-to-back frames with the consumer always ready
    out_ready = 1'b1; mon_en = 1'b1;
    send_frame(16'h8001, 99, 0, 1'b0, 1'b0);
    send_frame(16'h7FFE, 99, 0, 1'b0, 1'b0);
    idle(2);
    mon_en = 1'b0; out_ready = 1'b0;
    chk("b2b_count", 32'(mon_q.size()), 32'd2);
    if (mon_q.size() == 2) begin
      chk("b2b_word0", 32'(mon_q[0]), 32'h8001);
      chk("b2b_word1", 32'(mon_q[1]), 32'h7FFE);
    end
    chk("b2b_idle_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
